// File: rtl/wb_slave_mux.sv
// wb_slave_mux: one Wishbone B4 classic master fanned out to NUM_SLAVES slaves.
// The address map is set by parameters. The slave select is registered, which
// adds one decode cycle per access. Unmapped addresses, slave errors and slaves
// that never answer all end in a bus error. The failing address and its cause
// are kept in registers for software to read.
module wb_slave_mux #(
  parameter int                           NUM_SLAVES = 5,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int                           TIMEOUT    = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [ADDR_W-1:0]              wbm_adr_i,
  input  logic [DATA_W-1:0]              wbm_dat_i,
  input  logic [DATA_W/8-1:0]            wbm_sel_i,
  input  logic                           wbm_we_i,
  input  logic                           wbm_cyc_i,
  input  logic                           wbm_stb_i,
  output logic [DATA_W-1:0]              wbm_dat_o,
  output logic                           wbm_ack_o,
  output logic                           wbm_err_o,
  output logic [NUM_SLAVES*ADDR_W-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DATA_W-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*DATA_W/8-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]          wbs_we_o,
  output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]          wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]          wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]          wbs_err_i,
  output logic                           bus_err_o,
  output logic [ADDR_W-1:0]              err_adr_o,
  output logic [1:0]                     err_cause_o
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_e;
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_SLAVE    = 2'b11
  } cause_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cause_e            cause_q, cause_d;        // cause reported by the pending ERR cycle
  logic [ADDR_W-1:0] err_adr_q, err_adr_d;
  cause_e            err_cause_q, err_cause_d;

  logic                  hit;
  logic [SEL_W-1:0]      hit_idx;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  s_ack, s_err;
  logic [DATA_W-1:0]     s_dat;

  // Write-side signals go to every slave. Only cyc/stb pick one slave.
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};

  assign err_adr_o   = err_adr_q;
  assign err_cause_o = err_cause_q;

  // Address decode. The loop runs downwards, so the lowest matching index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((wbm_adr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[k*ADDR_W +: ADDR_W] & SLAVE_MASK[k*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // Pick the registered slave's response lines and build its one-hot strobe mask.
  always_comb begin
    sel_onehot = '0;
    s_ack      = 1'b0;
    s_err      = 1'b0;
    s_dat      = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
        s_ack         = wbs_ack_i[k];
        s_err         = wbs_err_i[k];
        s_dat         = wbs_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and bus outputs. Slave responses reach the master combinationally.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    err_adr_d   = err_adr_q;
    err_cause_d = err_cause_q;
    wbm_dat_o   = '0;
    wbm_ack_o   = 1'b0;
    wbm_err_o   = 1'b0;
    bus_err_o   = 1'b0;
    wbs_cyc_o   = '0;
    wbs_stb_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit) begin
            sel_d   = hit_idx;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            cause_d = CAUSE_UNMAPPED;
            state_d = S_ERR;
          end
        end
      end

      S_BUSY: begin
        wbs_cyc_o = sel_onehot & {NUM_SLAVES{wbm_cyc_i}};
        wbs_stb_o = sel_onehot & {NUM_SLAVES{wbm_cyc_i & wbm_stb_i}};
        wbm_dat_o = s_dat;
        if (!wbm_cyc_i) begin
          // The master abandoned the cycle. A slave answer is dropped and nothing is logged.
          state_d = S_IDLE;
        end else if (wbm_stb_i && s_err) begin
          // A slave error takes priority over an ack that arrives in the same cycle.
          wbm_err_o   = 1'b1;
          bus_err_o   = 1'b1;
          err_adr_d   = wbm_adr_i;
          err_cause_d = CAUSE_SLAVE;
          state_d     = S_IDLE;
        end else if (wbm_stb_i && s_ack) begin
          // An ack in the last allowed cycle still wins over the timeout.
          wbm_ack_o = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ERR: begin
        wbm_err_o   = 1'b1;
        bus_err_o   = 1'b1;
        err_adr_d   = wbm_adr_i;
        err_cause_d = cause_q;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and diagnostic registers. Reset is synchronous.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the clock edge.
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      cause_q     <= CAUSE_NONE;
      err_adr_q   <= '0;
      err_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      err_adr_q   <= err_adr_d;
      err_cause_q <= err_cause_d;
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Testbench for wb_slave_mux. Each access task works out the whole response
// schedule of the access from the address map and the bus rules, then pushes
// one expectation record per clock cycle. A single compare process checks
// every record at the falling edge. Directed accesses are also pinned with
// hand-computed literal values.
module tb_wb_slave_mux;

  localparam int NS = 5;
  localparam int TO = 8;
  // slave0 0x0000_0xxx, slave1 0x4000_xxxx, slave2 0x2000_01xx,
  // slave3 0x4xxx_xxxx (overlaps slave1), slave4 0x30xx_xxxx
  localparam logic [NS*32-1:0] BASES = {32'h3000_0000, 32'h4000_0000, 32'h2000_0100,
                                        32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFF00_0000, 32'hF000_0000, 32'hFFFF_FF00,
                                        32'hFFFF_0000, 32'hFFFF_F000};
  localparam int R_ACK = 0, R_ERR = 1, R_ACKERR = 2, R_NONE = 3;

  typedef logic [159:0] w_t;

  typedef struct {
    bit          chk;
    int          t;
    logic [NS-1:0] cyc, stb;
    logic        ack, err, bus_err;
    bit          dat_chk;
    logic [31:0] dat;
    logic [31:0] err_adr;
    logic [1:0]  err_cause;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      m_adr, m_wdat, m_rdat;
  logic [3:0]       m_sel;
  logic             m_we, m_cyc, m_stb, m_ack, m_err;
  logic [NS*32-1:0] s_adr, s_wdat, s_rdat;
  logic [NS*4-1:0]  s_sel;
  logic [NS-1:0]    s_we, s_cyc, s_stb, s_ack, s_err;
  logic             bus_err;
  logic [31:0]      err_adr;
  logic [1:0]       err_cause;

  exp_t        q[$];
  exp_t        ce;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl_err_adr;
  logic [1:0]  mdl_err_cause;

  int obs_ack_t, obs_ack_cnt, obs_err_t, obs_err_cnt, obs_berr_cnt, obs_stb_cnt;
  logic [NS-1:0] obs_stb_or, obs_cyc_or;
  logic [31:0]   obs_dat;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .NUM_SLAVES (NS),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLAVE_BASE (BASES),
    .SLAVE_MASK (MASKS),
    .TIMEOUT    (TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm_adr_i   (m_adr),
    .wbm_dat_i   (m_wdat),
    .wbm_sel_i   (m_sel),
    .wbm_we_i    (m_we),
    .wbm_cyc_i   (m_cyc),
    .wbm_stb_i   (m_stb),
    .wbm_dat_o   (m_rdat),
    .wbm_ack_o   (m_ack),
    .wbm_err_o   (m_err),
    .wbs_adr_o   (s_adr),
    .wbs_dat_o   (s_wdat),
    .wbs_sel_o   (s_sel),
    .wbs_we_o    (s_we),
    .wbs_cyc_o   (s_cyc),
    .wbs_stb_o   (s_stb),
    .wbs_dat_i   (s_rdat),
    .wbs_ack_i   (s_ack),
    .wbs_err_i   (s_err),
    .bus_err_o   (bus_err),
    .err_adr_o   (err_adr),
    .err_cause_o (err_cause)
  );

  task automatic check(input string name, input w_t act, input w_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference decode: the first slave whose masked base matches, or -1 if none does.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & MASKS[k*32 +: 32]) == (BASES[k*32 +: 32] & MASKS[k*32 +: 32])) return k;
    return -1;
  endfunction

  function automatic logic [31:0] gen_adr(input int cls);
    logic [31:0] b, m;
    if (cls >= NS) return $urandom;
    b = BASES[cls*32 +: 32];
    m = MASKS[cls*32 +: 32];
    return (b & m) | ($urandom & ~m);
  endfunction

  function automatic exp_t idle_exp(input int t);
    exp_t e;
    e.chk = 1'b1; e.t = t; e.cyc = '0; e.stb = '0;
    e.ack = 1'b0; e.err = 1'b0; e.bus_err = 1'b0;
    e.dat_chk = 1'b0; e.dat = '0; e.err_adr = '0; e.err_cause = '0;
    e.m_adr = '0; e.m_dat = '0; e.m_sel = '0; e.m_we = 1'b0;
    return e;
  endfunction

  task automatic obs_clear();
    obs_ack_t = -1; obs_ack_cnt = 0; obs_err_t = -1; obs_err_cnt = 0;
    obs_berr_cnt = 0; obs_stb_cnt = 0; obs_stb_or = '0; obs_cyc_or = '0; obs_dat = '0;
  endtask

  // Drive one clock cycle and queue what the outputs must be during that cycle.
  task automatic drive_cycle(input bit r, input bit cyc, input bit stb,
                             input logic [NS-1:0] ack, input logic [NS-1:0] err, input exp_t e);
    rst = r; m_cyc = cyc; m_stb = stb; s_ack = ack; s_err = err;
    e.err_adr = mdl_err_adr; e.err_cause = mdl_err_cause;
    e.m_adr = m_adr; e.m_dat = m_wdat; e.m_sel = m_sel; e.m_we = m_we;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    m_adr = $urandom; m_wdat = $urandom; m_sel = 4'($urandom); m_we = 1'($urandom);
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, idle_exp(0));
  endtask

  // One master access. Cycle t=0 is the decode cycle, and the slave sees stb from t=1.
  task automatic access(input logic [31:0] adr, input bit we, input int resp, input int lat,
                        input int abort_at, input bit late_same, input logic [31:0] rdat);
    int tgt, nb;
    bit done, ended;
    logic [NS-1:0] oh, av, ev;
    exp_t e;
    tgt = decode(adr);
    m_adr = adr; m_we = we; m_wdat = $urandom; m_sel = 4'($urandom);
    for (int k = 0; k < NS; k++) s_rdat[k*32 +: 32] = $urandom;
    if (tgt >= 0) s_rdat[tgt*32 +: 32] = rdat;
    obs_clear();
    drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, idle_exp(0));
    if (tgt < 0) begin
      e = idle_exp(1); e.err = 1'b1; e.bus_err = 1'b1; e.dat_chk = 1'b1;
      drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, e);
      mdl_err_adr = adr; mdl_err_cause = 2'b01;
      return;
    end
    oh = NS'(1) << tgt;
    if (abort_at > 0) begin
      for (int t = 1; t <= abort_at; t++) begin
        e = idle_exp(t); e.cyc = oh; e.stb = oh;
        drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, e);
      end
      drive_cycle(1'b0, 1'b0, 1'b0, late_same ? oh : '0, '0, idle_exp(abort_at + 1));
      drive_cycle(1'b0, 1'b0, 1'b0, late_same ? '0 : oh, '0, idle_exp(abort_at + 2));
      return;
    end
    ended = (resp != R_NONE) && (lat <= TO);
    nb = ended ? lat : TO;
    for (int t = 1; t <= nb; t++) begin
      e = idle_exp(t); e.cyc = oh; e.stb = oh;
      done = ended && (t == lat);
      av = (done && resp != R_ERR) ? oh : '0;
      ev = (done && resp != R_ACK) ? oh : '0;
      if (done && resp == R_ACK) begin
        e.ack = 1'b1; e.dat_chk = 1'b1; e.dat = rdat;
      end else if (done) begin
        e.err = 1'b1; e.bus_err = 1'b1;
      end
      drive_cycle(1'b0, 1'b1, 1'b1, av, ev, e);
      if (done && resp != R_ACK) begin
        mdl_err_adr = adr; mdl_err_cause = 2'b11;
      end
    end
    if (!ended) begin
      e = idle_exp(TO + 1); e.err = 1'b1; e.bus_err = 1'b1; e.dat_chk = 1'b1;
      drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, e);
      mdl_err_adr = adr; mdl_err_cause = 2'b10;
    end
  endtask

  // Reset pulse in the middle of an access to a mapped slave. The master keeps
  // its request through the reset, so after reset the mux must be back in its
  // decode cycle with every output low.
  task automatic reset_mid(input logic [31:0] adr, input int nbusy);
    logic [NS-1:0] oh;
    exp_t e;
    oh = NS'(1) << decode(adr);
    m_adr = adr; m_we = 1'b0; m_wdat = $urandom; m_sel = 4'($urandom);
    obs_clear();
    drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, idle_exp(0));
    for (int t = 1; t <= nbusy; t++) begin
      e = idle_exp(t); e.cyc = oh; e.stb = oh;
      drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, e);
    end
    e = idle_exp(nbusy + 1); e.chk = 1'b0;
    drive_cycle(1'b1, 1'b1, 1'b1, '0, '0, e);
    mdl_err_adr = '0; mdl_err_cause = '0;
    drive_cycle(1'b0, 1'b1, 1'b1, '0, '0, idle_exp(nbusy + 2));
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, idle_exp(nbusy + 3));
  endtask

  // Compare process: checks every queued cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        ce = q.pop_front();
        if (ce.chk) begin
          check("slave_cyc", w_t'(s_cyc), w_t'(ce.cyc));
          check("slave_stb", w_t'(s_stb), w_t'(ce.stb));
          check("master_ack", w_t'(m_ack), w_t'(ce.ack));
          check("master_err", w_t'(m_err), w_t'(ce.err));
          check("bus_err", w_t'(bus_err), w_t'(ce.bus_err));
          check("err_adr", w_t'(err_adr), w_t'(ce.err_adr));
          check("err_cause", w_t'(err_cause), w_t'(ce.err_cause));
          check("bcast_adr", w_t'(s_adr), w_t'({NS{ce.m_adr}}));
          check("bcast_dat", w_t'(s_wdat), w_t'({NS{ce.m_dat}}));
          check("bcast_sel_we", w_t'({s_sel, s_we}), w_t'({{NS{ce.m_sel}}, {NS{ce.m_we}}}));
          if (ce.dat_chk) check("master_rdata", w_t'(m_rdat), w_t'(ce.dat));
          if (m_ack) begin obs_ack_cnt++; obs_ack_t = ce.t; obs_dat = m_rdat; end
          if (m_err) begin obs_err_cnt++; obs_err_t = ce.t; end
          if (bus_err) obs_berr_cnt++;
          if (s_stb != '0) obs_stb_cnt++;
          obs_stb_or = obs_stb_or | s_stb;
          obs_cyc_or = obs_cyc_or | s_cyc;
        end
      end
    end
  end

  initial begin
    int cls, r, lat, ab, mx, tgt;
    logic [31:0] adr;
    exp_t e;
    rst = 1'b1; m_adr = '0; m_wdat = '0; m_sel = '0; m_we = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; s_rdat = '0; s_ack = '0; s_err = '0;
    mdl_err_adr = '0; mdl_err_cause = '0;
    obs_clear();
    @(posedge clk); #1;
    e = idle_exp(0); e.chk = 1'b0;
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, e);
    idle_cycle();

    // Read from slave2. It acks in its 3rd strobe cycle, so the ack reaches the master at t=3.
    access(32'h2000_0104, 1'b0, R_ACK, 3, 0, 1'b0, 32'hDEAD_BEEF);
    check("rd_ack_cycle", w_t'(obs_ack_t), w_t'(3));
    check("rd_data", w_t'(obs_dat), w_t'(32'hDEAD_BEEF));
    check("rd_stb_only_slave2", w_t'(obs_stb_or), w_t'(5'b00100));
    check("rd_stb_cycles", w_t'(obs_stb_cnt), w_t'(3));
    idle_cycle();

    // Unmapped write: a one-cycle error at t=1, no slave cycle, address and cause logged.
    access(32'h9000_0000, 1'b1, R_ACK, 1, 0, 1'b0, 32'h0);
    check("unmapped_err_cycle", w_t'(obs_err_t), w_t'(1));
    check("unmapped_err_count", w_t'(obs_err_cnt), w_t'(1));
    check("unmapped_buserr_count", w_t'(obs_berr_cnt), w_t'(1));
    check("unmapped_no_cyc", w_t'(obs_cyc_or), w_t'(0));
    check("unmapped_err_adr", w_t'(err_adr), w_t'(32'h9000_0000));
    check("unmapped_cause", w_t'(err_cause), w_t'(2'b01));
    idle_cycle();

    // Slave0 never answers: 8 strobe cycles, then the ERR cycle at t=9.
    access(32'h0000_0010, 1'b0, R_NONE, 0, 0, 1'b0, 32'h0);
    check("timeout_stb_cycles", w_t'(obs_stb_cnt), w_t'(8));
    check("timeout_err_cycle", w_t'(obs_err_t), w_t'(9));
    check("timeout_cause", w_t'(err_cause), w_t'(2'b10));
    check("timeout_err_adr", w_t'(err_adr), w_t'(32'h0000_0010));

    // Overlapping map: slave1 and slave3 both decode 0x4000_0000, and only slave1 is strobed.
    access(32'h4000_0000, 1'b0, R_ACK, 1, 0, 1'b0, 32'h1234_5678);
    check("overlap_stb_slave1", w_t'(obs_stb_or), w_t'(5'b00010));
    check("overlap_ack_cycle", w_t'(obs_ack_t), w_t'(1));

    // Master drops cyc in the 2nd BUSY cycle and the slave acks one cycle later.
    access(32'h0000_0020, 1'b0, R_ACK, 5, 1, 1'b0, 32'h0);
    check("abort_no_ack", w_t'(obs_ack_cnt), w_t'(0));
    check("abort_cause_kept", w_t'(err_cause), w_t'(2'b10));
    access(32'h0000_0024, 1'b0, R_ACK, 2, 0, 1'b0, 32'hCAFE_0001);
    check("post_abort_ack_cycle", w_t'(obs_ack_t), w_t'(2));
    check("post_abort_data", w_t'(obs_dat), w_t'(32'hCAFE_0001));

    // Ack and err together from slave4: the err is forwarded and logged with cause 11.
    access(32'h3000_0040, 1'b1, R_ACKERR, 2, 0, 1'b0, 32'h0);
    check("ackerr_no_ack", w_t'(obs_ack_cnt), w_t'(0));
    check("ackerr_err_cycle", w_t'(obs_err_t), w_t'(2));
    check("ackerr_cause", w_t'(err_cause), w_t'(2'b11));
    check("ackerr_adr", w_t'(err_adr), w_t'(32'h3000_0040));

    // Reset during BUSY clears the logged error.
    reset_mid(32'h2000_0180, 3);
    check("reset_err_adr", w_t'(err_adr), w_t'(0));
    check("reset_err_cause", w_t'(err_cause), w_t'(0));

    // The ack arrives in the same cycle the timeout would expire. The ack wins and no error is flagged.
    access(32'h0000_0100, 1'b0, R_ACK, TO, 0, 1'b0, 32'h0BAD_F00D);
    check("collide_ack_cycle", w_t'(obs_ack_t), w_t'(TO));
    check("collide_no_buserr", w_t'(obs_berr_cnt), w_t'(0));
    check("collide_data", w_t'(obs_dat), w_t'(32'h0BAD_F00D));

    // Randomized traffic, sometimes back-to-back, checked only by the cycle model.
    for (int i = 0; i < 250; i++) begin
      cls = $urandom_range(0, NS + 1);
      adr = gen_adr(cls);
      tgt = decode(adr);
      if (tgt >= 0 && $urandom_range(0, 19) == 0) begin
        reset_mid(adr, $urandom_range(1, TO - 1));
      end else begin
        r = $urandom_range(0, 9);
        r = (r < 6) ? R_ACK : (r < 8) ? R_ERR : (r == 8) ? R_ACKERR : R_NONE;
        lat = $urandom_range(1, TO + 2);
        ab = 0;
        if (tgt >= 0 && $urandom_range(0, 7) == 0) begin
          mx = (r == R_NONE || lat > TO) ? TO - 1 : lat - 1;
          if (mx >= 1) ab = $urandom_range(1, mx);
        end
        access(adr, 1'($urandom), r, lat, ab, 1'($urandom), $urandom);
      end
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
